// File: rtl/truth_table_sweeper.sv
// Steps a 3-input circuit through all 8 input vectors, samples its output after a
// programmable settle time and compares the captured truth table to an expected code.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] measured,
  output logic [7:0] mismatch,
  output logic       pass
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [2:0] idx;
  logic [7:0] cnt;
  logic [7:0] shadow, shadow_n;
  logic [7:0] exp_l;
  logic       sample, last_sample;

  assign sample      = (state == DRIVE) && (cnt == LAST_CNT);
  assign last_sample = sample && (idx == 3'd7);

  // Shadow including the bit being captured this cycle, so results can be
  // loaded on the edge into DONE and be visible during the done pulse.
  always_comb begin
    shadow_n = shadow;
    if (sample) shadow_n[idx] = dut_out;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n        = state;
    busy           = 1'b0;
    done           = 1'b0;
    {in1, in2, in3} = 3'b000;
    case (state)
      IDLE:  if (start) state_n = DRIVE;
      DRIVE: begin
        busy            = 1'b1;
        {in1, in2, in3} = idx;
        if (last_sample) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 3'd0;
      cnt      <= 8'd0;
      shadow   <= 8'd0;
      exp_l    <= 8'd0;
      measured <= 8'd0;
      mismatch <= 8'd0;
      pass     <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        exp_l  <= expected;
        idx    <= 3'd0;
        cnt    <= 8'd0;
        shadow <= 8'd0;
      end
    end else if (state == DRIVE) begin
      shadow <= shadow_n;
      if (sample) begin
        cnt <= 8'd0;
        if (idx != 3'd7) idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 8'd1;
      end
      if (last_sample) begin
        measured <= shadow_n;
        mismatch <= shadow_n ^ exp_l;
        pass     <= (shadow_n == exp_l);
      end
    end
  end

endmodule
